mixer_level_ctrl: RTL and testbench
===================================

# mixer_level_ctrl

Sequences the 7-bit `level` input of the mixer so that gain changes arrive as a slow, click-free ramp instead of a jump. It accepts target levels through a valid/ready handshake and a mute request. It moves the applied level one step toward the effective target every `FRAMES_PER_STEP` audio frames, and updates the level only at a frame boundary (lrclk rising edge), never mid-word. It sits between the control/register side and the mixer's `level` port.

## Interface
- `FRAMES_PER_STEP`, default 4: number of lrclk frames between ±1 level steps; legal range 1..255.
- `RESET_LEVEL`, default 0: value of `level` and of the target register after reset; must be ≤ `LEVEL_MAX`.
- `clk` input, 1 bit: system clock; all logic runs on its rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `lrclk` input, 1 bit: I2S frame clock, already synchronous to `clk`; sampled, never used as a clock.
- `set_valid` input, 1 bit: a new target level is offered.
- `set_level` input, 7 bits: offered target level; values above `LEVEL_MAX` are clamped to `LEVEL_MAX`.
- `set_ready` output, 1 bit: target register can accept.
- `mute` input, 1 bit: level-sensitive; while high the effective target is 0.
- `level` output, 7 bits: applied level, driven to mixer `level`.
- `busy` output, 1 bit: a ramp is in progress.
- `done` output, 1 bit: single-cycle pulse when a ramp reaches its target.

## Operation
- Frame tick: `lrclk_prev` register; `tick = lrclk & ~lrclk_prev`, combinational, high for exactly one `clk` per frame.
- Target register `target`, 7 bits: loads `min(set_level, LEVEL_MAX)` on `set_valid & set_ready`.
- `set_ready` is constant 1 outside reset. A later accept overwrites an earlier one; the ramp redirects without restart.
- Effective target: `eff = mute ? 0 : target`. `mute` does not modify `target`, so releasing mute ramps back to `target`.
- States:
  - IDLE: `level == eff`.
  - UP: `level < eff`.
  - DOWN: `level > eff`.
- Transitions:
  - IDLE→UP/DOWN when `eff` differs from `level`; `frame_cnt` is cleared on this transition.
  - UP↔DOWN on reversal; `frame_cnt` is not cleared.
  - UP/DOWN→IDLE when `level` equals `eff` after a step, or when `eff` changes to equal the current `level`.
- Step counter: `frame_cnt` width 8. On `tick` in UP/DOWN:
  - if `frame_cnt == FRAMES_PER_STEP-1`: `level` ±1 and `frame_cnt` ← 0;
  - else `frame_cnt`+1.
- `level` never changes except on a `tick` cycle. It stays within 0..`LEVEL_MAX`.
- `busy = (state != IDLE)`.
- `done` is registered. It pulses for one cycle after the step that lands on `eff`. It does not pulse when IDLE is re-entered without a step.

## Timing
- Reset values: `level` = `RESET_LEVEL`, `target` = `RESET_LEVEL`, state IDLE, `frame_cnt` 0, `lrclk_prev` 0, `busy` 0, `done` 0, `set_ready` 0.
- `set_ready` rises on the first `clk` edge after `rst` deasserts.
- Accept to state change: `target` updates at the accept edge; state leaves IDLE on the next edge.
- Step latency: with a fresh ramp started before a frame, the first `level` change occurs on the `FRAMES_PER_STEP`-th subsequent tick. `level` is visible 1 `clk` after that tick.
- Full ramp length: a ramp of N steps takes N·`FRAMES_PER_STEP` ticks.
- Accept coinciding with `tick`: the step uses the old `eff`; the new target applies from the next tick.
- `mute` edge coinciding with `tick`: same rule as an accept; the step uses the old `eff`.
- Reset mid-ramp: all registers return to reset values immediately (asynchronous), and no `done` is issued.

## Structure
- Shared package `mixer_pkg`:
  - `LEVEL_W = 7`
  - `LEVEL_MAX = 7'd82` (last valid mixer table entry)
  - `typedef enum logic [1:0] {IDLE, UP, DOWN} lvl_state_t`
- One sub-module, `frame_tick`: lrclk rising-edge detector with asynchronous reset. It is reusable by the other bit-serial blocks.
- Everything else is in one `always_ff` plus next-state `always_comb`.

## Test plan
- Reset with `RESET_LEVEL=0`, toggle `lrclk` → `level`=0, `busy`=0, `done`=0, `set_ready` 0 during reset and 1 one clk after release.
- Accept `set_level=5`, `FRAMES_PER_STEP=4` → `level` increments 0→5, one step every 4 ticks, 20 ticks total; `busy` high throughout; single `done` pulse; `level` changes only 1 clk after a tick.
- Accept `set_level=100` → `target`=82; ramp ends at `level`=82 and never exceeds it.
- At `level`=10 ramping to 20, assert `mute` → DOWN to 0 with one `done`. Deassert `mute` → UP to 20 with a second `done`. `target` is still 20 throughout.
- Accept `set_level` equal to the current `level` → no `busy`, no `done`. Accept on the same cycle as `tick` → that step follows the old target.
- Assert `rst` while ramping at `level`=7 → `level`=`RESET_LEVEL` immediately, no `done`. After release, the block is idle and accepts a new target.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared definitions for the mixer control blocks: level width, the top of the
// mixer gain table, and the level-ramp state encoding.
package mixer_pkg;
  localparam int LEVEL_W = 7;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 7'd82;

  typedef enum logic [1:0] {IDLE, UP, DOWN} lvl_state_t;

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] l);
    return (l > LEVEL_MAX) ? LEVEL_MAX : l;
  endfunction
endpackage

// File: rtl/mixer_level_ctrl_frame_tick.sv
// lrclk rising-edge detector; lrclk is already in the clk domain, so this is a
// plain one-register edge detect usable by any bit-serial block.
module frame_tick (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lrclk_i,
  output logic tick_o
);
  logic lrclk_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lrclk_prev_q <= 1'b0;
    else       lrclk_prev_q <= lrclk_i;
  end

  assign tick_o = lrclk_i & ~lrclk_prev_q;
endmodule

// File: rtl/mixer_level_ctrl.sv
// Ramps the mixer level one step toward the requested (or muted) target every
// FRAMES_PER_STEP frames, changing it only on a frame boundary.
module mixer_level_ctrl
  import mixer_pkg::*;
#(
  parameter int unsigned          FRAMES_PER_STEP = 4,
  parameter logic [LEVEL_W-1:0]   RESET_LEVEL     = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lrclk_i,
  input  logic               set_valid_i,
  input  logic [LEVEL_W-1:0] set_level_i,
  output logic               set_ready_o,
  input  logic               mute_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  logic               tick;
  lvl_state_t         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d, target_q, target_d, eff, step_lvl;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               mute_q, ready_q, done_q, done_d, lt;

  frame_tick u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .lrclk_i(lrclk_i),
    .tick_o (tick)
  );

  // mute is registered so a mute edge on a tick cycle behaves like an accept:
  // the step taken on that tick still follows the old effective target.
  assign eff = mute_q ? '0 : target_q;
  assign lt  = level_q < eff;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    target_d    = (set_valid_i && ready_q) ? clamp_level(set_level_i) : target_q;
    step_lvl    = lt ? level_q + 7'd1 : level_q - 7'd1;
    case (state_q)
      IDLE: begin
        if (level_q != eff) begin
          state_d     = lt ? UP : DOWN;
          frame_cnt_d = '0;
        end
      end
      default: begin
        if (level_q == eff) begin
          state_d = IDLE;
        end else begin
          state_d = lt ? UP : DOWN;
          if (tick) begin
            if (frame_cnt_q == CNT_LAST) begin
              level_d     = step_lvl;
              frame_cnt_d = '0;
              if (step_lvl == eff) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      level_q     <= RESET_LEVEL;
      target_q    <= RESET_LEVEL;
      frame_cnt_q <= '0;
      mute_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      target_q    <= target_d;
      frame_cnt_q <= frame_cnt_d;
      mute_q      <= mute_i;
      ready_q     <= 1'b1;
      done_q      <= done_d;
    end
  end

  assign set_ready_o = ready_q;
  assign level_o     = level_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
endmodule

// File: tb/tb_mixer_level_ctrl.sv
// Directed bench for mixer_level_ctrl: a cycle table for a short ramp, then
// hand sequences for long ramps, clamping, mute, coincident accept and reset.
module tb_mixer_level_ctrl;
  logic       clk = 1'b0, rst = 1'b1, lrclk = 1'b0, set_valid = 1'b0, mute = 1'b0;
  logic [6:0] set_level = '0;
  logic       set_ready, busy, done;
  logic [6:0] level;

  int nvec = 0, nerr = 0, done_cnt = 0;

  mixer_level_ctrl #(.FRAMES_PER_STEP(4), .RESET_LEVEL(7'd0)) dut (
    .clk_i(clk), .rst_i(rst), .lrclk_i(lrclk), .set_valid_i(set_valid),
    .set_level_i(set_level), .set_ready_o(set_ready), .mute_i(mute),
    .level_o(level), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic v; logic [6:0] lvl; logic m; logic lr;
    int el; int eb; int ed;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [6:0] lvl, input logic m, input logic lr,
                     input int el, input int eb, input int ed);
    vec_t r;
    r = '{v, lvl, m, lr, el, eb, ed};
    tbl.push_back(r);
  endtask

  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic frame();
    lrclk = 1'b1; cyc();
    lrclk = 1'b0; cyc();
  endtask

  task automatic ramp(input int maxt, output int t);
    t = 0;
    while (busy && t < maxt) begin frame(); t++; end
  endtask

  initial begin
    int t, base, over;
    // ramp 0 -> 2 at 4 frames/step, one row per clk
    add(1, 7'd2, 0, 0, 0, 0, 0);
    add(0, 7'd0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      add(0, 7'd0, 0, 1, i / 4, (i < 8) ? 1 : 0, (i == 8) ? 1 : 0);
      add(0, 7'd0, 0, 0, i / 4, (i < 8) ? 1 : 0, 0);
    end

    // reset state, lrclk toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); lrclk = ~lrclk;
    end
    lrclk = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", set_ready, 0);
    rst = 1'b0;
    chk("ready_at_release", set_ready, 0);
    cyc();
    chk("ready_after_release", set_ready, 1);

    foreach (tbl[i]) begin
      set_valid = tbl[i].v; set_level = tbl[i].lvl; mute = tbl[i].m; lrclk = tbl[i].lr;
      cyc();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].el);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
    end
    set_valid = 1'b0;

    // fresh 0 -> 5 ramp: 20 ticks, level moves only on the tick edge
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    chk("rearm_level", level, 0);
    set_valid = 1'b1; set_level = 7'd5; cyc(); set_valid = 1'b0; cyc();
    chk("r5_busy_start", busy, 1);
    base = done_cnt;
    for (int k = 1; k <= 20; k++) begin
      lrclk = 1'b1; cyc();
      chk($sformatf("r5_t%0d_level", k), level, k / 4);
      chk($sformatf("r5_t%0d_done", k), done, (k == 20) ? 1 : 0);
      lrclk = 1'b0; cyc();
      chk($sformatf("r5_t%0d_hold", k), level, k / 4);
      chk($sformatf("r5_t%0d_busy", k), busy, (k < 20) ? 1 : 0);
    end
    chk("r5_done_count", done_cnt - base, 1);

    // clamp: 100 -> 82, 77 steps
    set_valid = 1'b1; set_level = 7'd100; cyc(); set_valid = 1'b0; cyc();
    base = done_cnt; t = 0; over = 0;
    while (busy && t < 400) begin
      frame(); t++;
      if (level > 7'd82) over = 1;
    end
    chk("clamp_ticks", t, 308);
    chk("clamp_level", level, 82);
    chk("clamp_over", over, 0);
    chk("clamp_done_count", done_cnt - base, 1);

    // down to 10, then head for 20 and mute two frames in
    set_valid = 1'b1; set_level = 7'd10; cyc(); set_valid = 1'b0; cyc();
    ramp(400, t);
    chk("down10_ticks", t, 288);
    chk("down10_level", level, 10);
    set_valid = 1'b1; set_level = 7'd20; cyc(); set_valid = 1'b0; cyc();
    frame(); frame();
    mute = 1'b1; cyc();
    base = done_cnt;
    ramp(100, t);
    chk("mute_ticks", t, 38);
    chk("mute_level", level, 0);
    chk("mute_busy", busy, 0);
    chk("mute_done_count", done_cnt - base, 1);
    mute = 1'b0; cyc(); cyc();
    chk("unmute_busy", busy, 1);
    base = done_cnt;
    ramp(200, t);
    chk("unmute_ticks", t, 80);
    chk("unmute_level", level, 20);
    chk("unmute_done_count", done_cnt - base, 1);

    // accept equal to current level: nothing happens
    base = done_cnt;
    set_valid = 1'b1; set_level = 7'd20; cyc(); set_valid = 1'b0; cyc();
    chk("equal_busy_a", busy, 0);
    frame(); frame();
    chk("equal_busy_b", busy, 0);
    chk("equal_level", level, 20);
    chk("equal_done_count", done_cnt - base, 0);

    // accept on the tick that steps: step follows the old target (22)
    set_valid = 1'b1; set_level = 7'd22; cyc(); set_valid = 1'b0; cyc();
    frame(); frame(); frame();
    lrclk = 1'b1; set_valid = 1'b1; set_level = 7'd10; cyc();
    set_valid = 1'b0;
    chk("coinc_step_level", level, 21);
    lrclk = 1'b0; cyc();
    chk("coinc_busy", busy, 1);
    frame(); frame(); frame(); frame();
    chk("coinc_redirect_level", level, 20);

    // reset while ramping at level 7
    set_valid = 1'b1; set_level = 7'd0; cyc(); set_valid = 1'b0; cyc();
    t = 0;
    while (level != 7'd7 && t < 100) begin frame(); t++; end
    chk("pre_rst_level", level, 7);
    base = done_cnt;
    rst = 1'b1; #1;
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", set_ready, 0);
    @(negedge clk); rst = 1'b0; cyc(); cyc();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", set_ready, 1);
    chk("post_rst_done_count", done_cnt - base, 0);
    set_valid = 1'b1; set_level = 7'd1; cyc(); set_valid = 1'b0; cyc();
    ramp(20, t);
    chk("post_rst_ticks", t, 4);
    chk("post_rst_level", level, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
